input_debouncer: RTL and testbench

Conditions raw asynchronous switch/button levels into clean, glitch-free, clock-synchronous levels before they reach the combinational logic stages (e.g. the two-input AND stage) in the design. Each channel is synchronised through two flops and then filtered, so an output changes only after its input has held a new value for a programmable number of consecutive cycles. One-cycle rise/fall pulses accompany every output change for downstream sequential consumers.

---
 rtl/input_debouncer_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 97 +++++++++
 rtl/input_debouncer.sv | 35 +++
 tb/tb_input_debouncer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : input_debouncer_pkg
//  Brief    : Shared defaults, channel state encoding and counter sizing.
//  Revision : 1.0 - initial release
// ============================================================================
package input_debouncer_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 16;
    localparam int DEFAULT_N_CH          = 2;

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_e;

    // Counter must hold values 0..STABLE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : input_debouncer_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Brief    : Two-flop synchroniser, stability counter and edge pulses, 1 bit.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CW     = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  C_TERM = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);

    logic          r_sync1_q, w_sync1_d;
    logic          r_sync2_q, w_sync2_d;
    logic [CW-1:0] r_cnt_q,   w_cnt_d;
    deb_state_e    r_state_q, w_state_d;
    logic          r_clean_q, w_clean_d;
    logic          r_rise_q,  w_rise_d;
    logic          r_fall_q,  w_fall_d;

    always_comb begin
        w_sync1_d = i_raw;
        w_sync2_d = r_sync1_q;
        w_cnt_d   = r_cnt_q;
        w_state_d = r_state_q;
        w_clean_d = r_clean_q;
        w_rise_d  = 1'b0;
        w_fall_d  = 1'b0;

        case (r_state_q)
            ST_STABLE: begin
                if (r_sync2_q != r_clean_q) begin
                    w_cnt_d   = C_ONE;
                    w_state_d = ST_COUNTING;
                end else begin
                    w_cnt_d   = '0;
                end
            end
            ST_COUNTING: begin
                // A single matching sample throws away all accumulated credit.
                if (r_sync2_q == r_clean_q) begin
                    w_cnt_d   = '0;
                    w_state_d = ST_STABLE;
                end else if (r_cnt_q == C_TERM) begin
                    w_clean_d = r_sync2_q;
                    w_rise_d  = r_sync2_q;
                    w_fall_d  = ~r_sync2_q;
                    w_cnt_d   = '0;
                    w_state_d = ST_STABLE;
                end else begin
                    w_cnt_d   = r_cnt_q + C_ONE;
                end
            end
            default: begin
                w_cnt_d   = '0;
                w_state_d = ST_STABLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1_q <= 1'b0;
            r_sync2_q <= 1'b0;
            r_cnt_q   <= '0;
            r_state_q <= ST_STABLE;
            r_clean_q <= 1'b0;
            r_rise_q  <= 1'b0;
            r_fall_q  <= 1'b0;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
            r_cnt_q   <= w_cnt_d;
            r_state_q <= w_state_d;
            r_clean_q <= w_clean_d;
            r_rise_q  <= w_rise_d;
            r_fall_q  <= w_fall_d;
        end
    end

    assign o_clean = r_clean_q;
    assign o_rise  = r_rise_q;
    assign o_fall  = r_fall_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : input_debouncer
//  Brief    : N independent debounced channels with registered edge pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int N_CH          = DEFAULT_N_CH,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_raw   (raw_in[i]),
            .o_clean (clean_out[i]),
            .o_rise  (rise_pulse[i]),
            .o_fall  (fall_pulse[i])
        );
    end

endmodule : input_debouncer
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_debouncer
//  Brief    : Directed scoreboard bench; default instance plus a 4-cycle one.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] raw16, raw4;
    logic [1:0] clean16, rise16, fall16;
    logic [1:0] clean4, rise4, fall4;

    always #5 clk = ~clk;

    input_debouncer u16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw16),
        .clean_out  (clean16),
        .rise_pulse (rise16),
        .fall_pulse (fall16)
    );

    input_debouncer #(.N_CH(2), .STABLE_CYCLES(4)) u4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw4),
        .clean_out  (clean4),
        .rise_pulse (rise4),
        .fall_pulse (fall4)
    );

    typedef struct {
        int         cyc;
        bit         d4;
        logic [1:0] c;
        logic [1:0] r;
        logic [1:0] f;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int ofs, input bit d4, input logic [1:0] c,
                             input logic [1:0] r, input logic [1:0] f, input string tag);
        exp_t e;
        e.cyc = cyc + ofs;
        e.d4  = d4;
        e.c   = c;
        e.r   = r;
        e.f   = f;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic expect_span(input int from, input int to, input bit d4, input logic [1:0] c,
                               input logic [1:0] r, input logic [1:0] f, input string tag);
        for (int k = from; k <= to; k++) expect_at(k, d4, c, r, f, tag);
    endtask

    task automatic chk(input string tag, input string what, input logic [1:0] got,
                       input logic [1:0] exp, input int at);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s %s @cyc%0d: observed %b expected %b", tag, what, at, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag, "clean", sb[i].d4 ? clean4 : clean16, sb[i].c, cyc);
                chk(sb[i].tag, "rise",  sb[i].d4 ? rise4  : rise16,  sb[i].r, cyc);
                chk(sb[i].tag, "fall",  sb[i].d4 ? fall4  : fall16,  sb[i].f, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        raw16 = 2'b11;
        raw4  = 2'b00;

        // Reset held three cycles with raw high on the default instance.
        expect_span(1, 3, 1'b0, 2'b00, 2'b00, 2'b00, "rst16");
        expect_span(1, 3, 1'b1, 2'b00, 2'b00, 2'b00, "rst4");
        tick(3);
        rst_n = 1'b1;
        expect_span(1, 17, 1'b0, 2'b00, 2'b00, 2'b00, "rel16_wait");
        expect_at(18, 1'b0, 2'b11, 2'b11, 2'b00, "rel16_flip");
        expect_at(19, 1'b0, 2'b11, 2'b00, 2'b00, "rel16_after");
        expect_at(19, 1'b1, 2'b00, 2'b00, 2'b00, "rel4_idle");
        tick(20);

        // Clean step on ch0.
        raw4 = 2'b01;
        expect_span(1, 5, 1'b1, 2'b00, 2'b00, 2'b00, "step_wait");
        expect_at(6, 1'b1, 2'b01, 2'b01, 2'b00, "step_flip");
        expect_at(7, 1'b1, 2'b01, 2'b00, 2'b00, "step_after");
        tick(8);

        raw4 = 2'b00;
        expect_span(1, 5, 1'b1, 2'b01, 2'b00, 2'b00, "fall_wait");
        expect_at(6, 1'b1, 2'b00, 2'b00, 2'b01, "fall_flip");
        expect_at(7, 1'b1, 2'b00, 2'b00, 2'b00, "fall_after");
        tick(8);

        // Glitch one cycle shorter than the filter window.
        raw4 = 2'b01;
        expect_span(1, 10, 1'b1, 2'b00, 2'b00, 2'b00, "glitch");
        tick(3);
        raw4 = 2'b00;
        tick(8);

        // Bounce on ch1, then settle high.
        expect_span(1, 4, 1'b1, 2'b00, 2'b00, 2'b00, "bounce");
        raw4 = 2'b10; tick(1);
        raw4 = 2'b00; tick(1);
        raw4 = 2'b10; tick(1);
        raw4 = 2'b00; tick(1);
        raw4 = 2'b10;
        expect_span(1, 5, 1'b1, 2'b00, 2'b00, 2'b00, "bounce_wait");
        expect_at(6, 1'b1, 2'b10, 2'b10, 2'b00, "bounce_flip");
        expect_at(7, 1'b1, 2'b10, 2'b00, 2'b00, "bounce_after");
        tick(8);

        // Both channels flip in opposite directions on the same edge.
        raw4 = 2'b01;
        expect_span(1, 5, 1'b1, 2'b10, 2'b00, 2'b00, "simA_wait");
        expect_at(6, 1'b1, 2'b01, 2'b01, 2'b10, "simA_flip");
        expect_at(7, 1'b1, 2'b01, 2'b00, 2'b00, "simA_after");
        tick(8);
        raw4 = 2'b10;
        expect_span(1, 5, 1'b1, 2'b01, 2'b00, 2'b00, "simB_wait");
        expect_at(6, 1'b1, 2'b10, 2'b10, 2'b01, "simB_flip");
        expect_at(7, 1'b1, 2'b10, 2'b00, 2'b00, "simB_after");
        tick(8);

        // Reset while ch0 count is at 2; progress must be lost.
        raw4 = 2'b11;
        expect_span(1, 4, 1'b1, 2'b10, 2'b00, 2'b00, "mid_count");
        tick(4);
        rst_n = 1'b0;
        expect_span(1, 2, 1'b1, 2'b00, 2'b00, 2'b00, "mid_rst");
        tick(2);
        rst_n = 1'b1;
        expect_span(1, 5, 1'b1, 2'b00, 2'b00, 2'b00, "mid_rel_wait");
        expect_at(6, 1'b1, 2'b11, 2'b11, 2'b00, "mid_rel_flip");
        expect_at(7, 1'b1, 2'b11, 2'b00, 2'b00, "mid_rel_after");
        tick(9);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_input_debouncer
`default_nettype wire
